// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential signed multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

    localparam int ABS_W = 32;

    // Magnitude of a sign-extended operand; callers truncate to their own width.
    function automatic logic [ABS_W-1:0] abs_n(input logic signed [ABS_W-1:0] v);
        return v[ABS_W-1] ? ABS_W'(-v) : ABS_W'(v);
    endfunction

endpackage

// File: rtl/seq_mult_adder.sv
// N-bit ripple adder with carry in/out, used as the multiplier's datapath adder.
module n_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    output logic [N-1:0] S,
    output logic         co
);

    assign {co, S} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, ci};

endmodule

// File: rtl/seq_mult.sv
// Signed shift-and-add multiplier: magnitudes are multiplied over N cycles,
// then the product is conditionally negated.
//   state | meaning
//   IDLE  | ready for an operand pair
//   CALC  | N add/shift iterations in progress
//   DONE  | product valid, waiting for the consumer
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] P
);

    localparam int CW = $clog2(N) + 1;

    mult_state_t     state, state_next;
    logic [CW-1:0]   count;
    logic [N-1:0]    mag_a;
    logic [N-1:0]    acc_hi;
    logic [N-1:0]    acc_lo;
    logic            neg;
    logic [N-1:0]    add_s;
    logic            add_co;
    logic [N:0]      sum_sel;
    logic [2*N-1:0]  acc_next;
    logic            last_iter;

    n_adder #(.N(N)) u_adder (
        .A  (acc_hi),
        .B  (mag_a),
        .ci (1'b0),
        .S  (add_s),
        .co (add_co)
    );

    assign in_ready  = (state == IDLE);
    assign last_iter = (count == CW'(N - 1));

    always_comb begin
        state_next = state;
        sum_sel    = {1'b0, acc_hi};
        if (acc_lo[0]) begin
            sum_sel = {add_co, add_s};
        end
        acc_next = {sum_sel, acc_lo[N-1:1]};
        case (state)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            mag_a     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            neg       <= 1'b0;
            P         <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_a  <= N'(abs_n(ABS_W'(signed'(A))));
                        acc_lo <= N'(abs_n(ABS_W'(signed'(B))));
                        acc_hi <= '0;
                        neg    <= A[N-1] ^ B[N-1];
                        count  <= '0;
                    end
                end
                CALC: begin
                    acc_hi <= acc_next[2*N-1:N];
                    acc_lo <= acc_next[N-1:0];
                    count  <= count + CW'(1);
                    // P only moves here, so consumers never see partial sums.
                    if (last_iter) begin
                        P         <= neg ? -acc_next : acc_next;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: vector table, handshake corner cases, random products.
module tb_seq_mult;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] P;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mult #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

    typedef struct {
        logic signed [7:0] a;
        logic signed [7:0] b;
        logic [15:0]       p;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_prod(input int a, input int b);
        int pr;
        pr = a * b;
        return pr[15:0];
    endfunction

    // Issue one operand pair, optionally stall the consumer, then release the result.
    task automatic do_op(input logic signed [7:0] a, input logic signed [7:0] b,
                         input int stall, input logic [15:0] exp_p,
                         output logic [15:0] p_got, output int lat);
        int g;
        logic [15:0] p0;
        logic hold_bad;
        g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1; g++;
        end
        chk("in_ready_before_op", 32'(in_ready), 32'd1);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        hold_bad = 1'b0;
        p0 = P;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (P !== p0 || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad = 1'b1;
        end
        if (stall > 0) chk("stall_hold", 32'(hold_bad), 32'd0);
        p_got = P;
        chk("op_product", 32'(p_got), 32'(exp_p));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid_ready", {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] p;
        int lat;
        int g;
        logic signed [7:0] ra, rb;

        vecs[0] = '{a:  8'sd5,    b:  8'sd10,   p: 16'd50};
        vecs[1] = '{a: -8'sd3,    b:  8'sd7,    p: 16'hFFEB};
        vecs[2] = '{a:  8'sd127,  b: -8'sd128,  p: 16'hC080};
        vecs[3] = '{a: -8'sd128,  b: -8'sd128,  p: 16'h4000};
        vecs[4] = '{a:  8'sd0,    b: -8'sd5,    p: 16'h0000};
        vecs[5] = '{a: -8'sd1,    b: -8'sd1,    p: 16'h0001};
        vecs[6] = '{a: -8'sd128,  b:  8'sd127,  p: 16'hC080};
        vecs[7] = '{a: -8'sd7,    b:  8'sd0,    p: 16'h0000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_P", 32'(P), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, 0, vecs[i].p, p, lat);
            chk("table_latency", 32'(lat), 32'd8);
        end

        // Consumer back-pressure for 20 cycles.
        do_op(8'sd11, -8'sd9, 20, 16'hFF9D, p, lat);

        // in_valid held high through CALC of 2*3 with 9*9 waiting behind it.
        A = 8'd2; B = 8'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 8'd9; B = 8'd9;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("busy_first_latency", 32'(lat), 32'd8);
        chk("busy_first_P", 32'(P), 32'd6);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("busy_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_second_accepted", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("busy_second_latency", 32'(lat), 32'd8);
        chk("busy_second_P", 32'(P), 32'd81);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset asserted mid-CALC after four iterations.
        A = 8'd100; B = 8'd100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("midcalc_reset_P", 32'(P), 32'd0);
        chk("midcalc_reset_out_valid", 32'(out_valid), 32'd0);
        chk("midcalc_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(8'sd12, -8'sd12, 0, 16'hFF70, p, lat);
        chk("post_reset_latency", 32'(lat), 32'd8);

        // Random operands against the arithmetic model, with random stalls.
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            g = int'($urandom_range(0, 3));
            do_op(ra, rb, g, ref_prod(int'(ra), int'(rb)), p, lat);
            if (lat != 8) chk("random_latency", 32'(lat), 32'd8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
